mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single unified memory port between the IF stage (instruction fetch)
//  and the MEM stage (load/store). FSM grants one requester at a time, holds the memory
//  request until mem_ready, returns read data with a one-cycle valid pulse, and drives
//  per-stage stall lines consumed by the hazard unit to freeze the pipeline.
// PARAMETERS
//  ADDR_W       16  address width, both requesters and memory
//  DATA_W       16  data width
//  TIMEOUT_CYC  64  max wait cycles per transaction (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, all state on posedge
//  reset      in   1       reset, synchronous, active-high
//  if_req     in   1       fetch request; held with if_addr stable until if_valid
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched instruction, valid when if_valid=1
//  if_valid   out  1       one-cycle fetch completion pulse
//  if_stall   out  1       if_req & ~if_valid
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata stable until d_valid
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid when d_valid=1 and access was a load
//  d_valid    out  1       one-cycle data completion pulse (loads and stores)
//  d_stall    out  1       d_req & ~d_valid
//  mem_req    out  1       memory request, high for whole transaction
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, sampled when mem_ready=1
//  mem_ready  in   1       transaction completes on posedge where mem_req=1 & mem_ready=1
//  busy       out  1       FSM not IDLE
//  err        out  1       sticky timeout flag
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (rdata regs 0, valids 0, mem_* 0, err 0).
//  - States: IDLE, DATA, FETCH. mem_req=1 exactly in DATA/FETCH; busy=same.
//  - IDLE, per posedge: d_req (unmasked) -> DATA; else if_req (unmasked) -> FETCH; else stay.
//    Fixed priority: data beats fetch (older instruction first).
//  - Masking: a requester whose valid is high this cycle is ignored by arbitration, so
//    its held req is not relaunched; its next request is taken from the following cycle.
//  - On entry, addr/we/wdata are latched into mem_* regs; requester input changes during
//    the transaction are ignored. FETCH always drives mem_we=0, mem_wdata=0.
//  - DATA/FETCH: hold mem_* stable while mem_ready=0. On posedge with mem_ready=1:
//    -> IDLE; the granted side's valid=1 for the next cycle; rdata reg loads mem_rdata
//    (d_rdata only for loads; stores leave d_rdata unchanged); mem_* regs clear to 0.
//  - Latency: req seen at posedge k, mem_req high in cycle after k; zero-wait memory ->
//    valid in cycle after k+1. Min 2 cycles req->valid; back-to-back transactions every
//    2 cycles (one IDLE cycle between grants).
//  - Simultaneous if_req+d_req: DATA served, FETCH launched on the IDLE cycle after it;
//    if_stall stays 1 throughout.
//  - Valid pulses exactly once per transaction; never both valids in one cycle.
//  - Reset mid-transaction: next cycle IDLE, mem_req=0, no valid pulse; transaction
//    abandoned, memory must tolerate a dropped mem_req.
//  - mem_ready while IDLE is ignored.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined: wait counter (clog2(TIMEOUT_CYC)+1 bits) clears on entry to
//    DATA/FETCH, +1 per cycle with mem_ready=0. When TIMEOUT_CYC cycles elapse with no
//    mem_ready: -> IDLE, granted side's valid pulses with rdata=0, err=1 sticky until reset.
//    mem_ready on the same edge as expiry wins (normal completion).
//  - Not defined: no counter; err tied 0; FSM waits indefinitely for mem_ready.
// TESTING
//  1. reset=1 two cycles, random inputs -> all outputs 0, busy=0 at every sample.
//  2. mem_ready=1, if_req=1 if_addr=0x0010, mem_rdata=0xA5C3 -> mem_req=1 mem_addr=0x0010
//     one cycle after req; if_valid=1 if_rdata=0xA5C3 two cycles after req; if_stall=0 then.
//  3. if_req (addr 0x0004) + d_req d_we=1 d_addr=0x0200 d_wdata=0x1234 same cycle ->
//     first mem_we=1 addr 0x0200 data 0x1234, d_valid; then mem_we=0 addr 0x0004, if_valid.
//  4. d_req load addr 0x0300, mem_ready low 3 cycles then high with 0xBEEF -> mem_addr
//     stable 4 cycles, d_valid one cycle after ready, d_rdata=0xBEEF, single pulse.
//  5. reset=1 during FETCH wait state -> next cycle mem_req=0, busy=0; no if_valid ever.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ready=0 on fetch -> after 8 wait cycles if_valid=1
//     if_rdata=0, err=1 held; without macro: mem_req still 1, err=0 at cycle 100.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (IF) and load/store
//   (MEM). One requester is granted at a time. Data requests take priority
//   over fetch requests. The memory request is held until mem_ready. Read data
//   is returned together with a one-cycle valid pulse.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     Adds a per-transaction wait counter. When TIMEOUT_CYC cycles pass with
//     no mem_ready, the granted side completes with rdata=0 and err is set
//     (sticky until reset). When the macro is undefined, err is tied to 0.
//
//   Ports
//     clk, reset                         clock; synchronous active-high reset
//     if_req/if_addr                     fetch request, address
//     if_rdata/if_valid/if_stall         fetch result, completion pulse, stall
//     d_req/d_we/d_addr/d_wdata          data request (store when d_we=1)
//     d_rdata/d_valid/d_stall            load result, completion pulse, stall
//     mem_req/mem_we/mem_addr/mem_wdata  memory request side
//     mem_rdata/mem_ready                memory response side
//     busy                               a transaction is in flight
//     err                                sticky timeout flag
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH} state_t;

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                expire;

  // Expiry happens on the edge that closes the TIMEOUT_CYC-th wait cycle.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = '0;
`endif
        // A requester whose valid is high this cycle still holds its old
        // request, so it is masked out of arbitration.
        if (d_req && !d_valid_q) begin
          state_d     = S_DATA;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_req && !if_valid_q) begin
          state_d     = S_FETCH;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      S_DATA, S_FETCH: begin
        if (mem_ready) begin
          state_d     = S_IDLE;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == S_DATA) begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (expire) begin
          state_d     = S_IDLE;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          err_d       = 1'b1;
          if (state_q == S_DATA) begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req   = (state_q != S_IDLE);
  assign busy      = mem_req;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
`ifdef MEM_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid, if_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_valid, d_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready, busy, err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 data, 2 fetch), the
  // captured request, waited cycles, and the values handed back.
  int            owner = 0;
  int            waited = 0;
  logic          r_we = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_wdata = '0;
  logic [DW-1:0] got_if = '0, got_d = '0;
  logic          done_if = 1'b0, done_d = 1'b0;
  logic          sticky_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic nif, nd;
    logic [DW-1:0] rd;
    nif = 1'b0;
    nd  = 1'b0;
    if (reset) begin
      owner = 0; waited = 0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
      got_if = '0; got_d = '0; sticky_err = 1'b0;
    end else if (owner == 0) begin
      if (d_req && !done_d) begin
        owner = 1; waited = 0; r_we = d_we; r_addr = d_addr; r_wdata = d_wdata;
      end else if (if_req && !done_if) begin
        owner = 2; waited = 0; r_we = 1'b0; r_addr = if_addr; r_wdata = '0;
      end
    end else if (mem_ready || (TIMED && waited == TO - 1)) begin
      rd = mem_ready ? mem_rdata : '0;
      if (!mem_ready) sticky_err = 1'b1;
      if (owner == 1) begin
        nd = 1'b1;
        if (!r_we || !mem_ready) got_d = rd;
      end else begin
        nif = 1'b1;
        got_if = rd;
      end
      owner = 0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
    end else begin
      waited++;
    end
    done_if = nif;
    done_d  = nd;
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, owner != 0);
    chk("busy", busy, owner != 0);
    chk("mem_we", mem_we, r_we);
    chk("mem_addr", mem_addr, r_addr);
    chk("mem_wdata", mem_wdata, r_wdata);
    chk("if_valid", if_valid, done_if);
    chk("d_valid", d_valid, done_d);
    chk("if_rdata", if_rdata, got_if);
    chk("d_rdata", d_rdata, got_d);
    chk("if_stall", if_stall, if_req & ~done_if);
    chk("d_stall", d_stall, d_req & ~done_d);
    chk("err", err, sticky_err);
    chk("one_valid", if_valid & d_valid, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  logic ip, dp;

  initial begin
    reset = 1'b1;
    idle_inputs();

    // 1: reset with random inputs
    for (int unsigned i = 0; i < 2; i++) begin
      if_req = 1'($urandom); if_addr = 16'($urandom); d_req = 1'($urandom);
      d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
    end
    reset = 1'b0;
    idle_inputs();
    step();

    // 2: zero-wait fetch
    if_req = 1'b1; if_addr = 16'h0010; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
    step();
    chk("t2_mem_req", mem_req, 1'b1);
    chk("t2_mem_addr", mem_addr, 16'h0010);
    step();
    chk("t2_if_valid", if_valid, 1'b1);
    chk("t2_if_rdata", if_rdata, 16'hA5C3);
    chk("t2_if_stall", if_stall, 1'b0);
    idle_inputs();
    step();

    // 3: simultaneous requests, data first
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    step();
    chk("t3_st_we", mem_we, 1'b1);
    chk("t3_st_addr", mem_addr, 16'h0200);
    chk("t3_st_wdata", mem_wdata, 16'h1234);
    chk("t3_if_stall", if_stall, 1'b1);
    step();
    chk("t3_d_valid", d_valid, 1'b1);
    chk("t3_if_stall2", if_stall, 1'b1);
    d_req = 1'b0;
    step();
    chk("t3_ld_we", mem_we, 1'b0);
    chk("t3_ld_addr", mem_addr, 16'h0004);
    step();
    chk("t3_if_valid", if_valid, 1'b1);
    idle_inputs();
    step();

    // 4: load with three wait cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t4_addr_hold", mem_addr, 16'h0300);
      if (i < 3) step();
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    chk("t4_d_valid", d_valid, 1'b1);
    chk("t4_d_rdata", d_rdata, 16'hBEEF);
    idle_inputs();
    step();
    chk("t4_single_pulse", d_valid, 1'b0);

    // 5: reset during a fetch wait state
    if_req = 1'b1; if_addr = 16'h0044;
    step();
    step();
    reset = 1'b1;
    step();
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_busy", busy, 1'b0);
    reset = 1'b0; if_req = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("t5_no_valid", if_valid, 1'b0);
    end

    // Randomized traffic against the model
    ip = 1'b0; dp = 1'b0;
    for (int unsigned c = 0; c < 400; c++) begin
      if (if_valid) ip = 1'b0;
      if (d_valid) dp = 1'b0;
      if (!ip && ($urandom_range(0, 2) == 0)) begin
        ip = 1'b1; if_addr = 16'($urandom);
      end
      if (!dp && ($urandom_range(0, 2) == 0)) begin
        dp = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if_req = ip;
      d_req = dp;
      mem_ready = ($urandom_range(0, 9) < 6);
      mem_rdata = 16'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    step();

    // 6: memory never ready on a fetch
    if_req = 1'b1; if_addr = 16'h0080;
    step();
`ifdef MEM_TIMEOUT_EN
    for (int unsigned i = 0; i < TO; i++) step();
    chk("t6_if_valid", if_valid, 1'b1);
    chk("t6_if_rdata", if_rdata, 16'h0000);
    chk("t6_err", err, 1'b1);
    if_req = 1'b0;
    step();
    step();
    chk("t6_err_held", err, 1'b1);
`else
    for (int unsigned i = 0; i < 99; i++) step();
    chk("t6_mem_req", mem_req, 1'b1);
    chk("t6_err", err, 1'b0);
`endif
    reset = 1'b1;
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
